// File: rtl/next_pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_fetch_if
// Brief    : Fetch/issue/resolve bundle between next_pc_fetch and its
//            instruction memory, decode stage and branch-resolve logic.
// Revision : 1.0 - initial release
// ============================================================================
interface next_pc_fetch_if #(
  parameter int CNT_W = 32
) ();

  logic [63:0]      StartPC;
  logic [63:0]      BusImm;
  logic             Branch;
  logic             Uncondbranch;
  logic             ALUZero;
  logic             ResolveValid;
  logic             IMemReq;
  logic [63:0]      IMemAddr;
  logic             IMemAck;
  logic [31:0]      IMemData;
  logic [31:0]      Imm32;
  logic             InstrValid;
  logic             InstrReady;
  logic [CNT_W-1:0] InstrCount;

  // Fetch unit side
  modport master (
    input  StartPC, BusImm, Branch, Uncondbranch, ALUZero, ResolveValid,
    input  IMemAck, IMemData, InstrReady,
    output IMemReq, IMemAddr, Imm32, InstrValid, InstrCount
  );

  // Memory / decode / resolve side
  modport slave (
    output StartPC, BusImm, Branch, Uncondbranch, ALUZero, ResolveValid,
    output IMemAck, IMemData, InstrReady,
    input  IMemReq, IMemAddr, Imm32, InstrValid, InstrCount
  );

endinterface
`default_nettype wire

// File: rtl/next_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_fetch
// Brief    : Program counter with a FETCH -> ISSUE -> RESOLVE handshake loop.
//            Fetches the word at PC, holds it for decode, then waits for the
//            branch outcome to advance PC by 4 or by the scaled offset.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_fetch #(
  parameter int CNT_W = 32
) (
  input  wire logic       CLK,
  input  wire logic       Reset,
  next_pc_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    ISSUE   = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  localparam logic [63:0]      c_PC_STEP = 64'd4;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [63:0]      r_pc;
  logic [31:0]      r_imm32;
  logic [CNT_W-1:0] r_count;

  logic             w_req;
  logic             w_valid;
  logic             w_load_instr;
  logic             w_retire;
  logic             w_take;
  logic [63:0]      w_offset;
  logic [63:0]      w_pc_nxt;

  // State register; reset always returns to IDLE, dropping any open handshake
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state handshake strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    w_load_instr = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        w_req = 1'b1;
        if (bus.IMemAck) begin
          w_load_instr = 1'b1;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        w_valid = 1'b1;
        if (bus.InstrReady) begin
          w_state_nxt = RESOLVE;
        end
      end
      RESOLVE: begin
        if (bus.ResolveValid) begin
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Branch target: word offset scaled to bytes, overflow bits simply dropped
  always_comb begin
    w_take   = bus.Uncondbranch | (bus.Branch & bus.ALUZero);
    w_offset = {bus.BusImm[61:0], 2'b00};
    w_pc_nxt = r_pc + (w_take ? w_offset : c_PC_STEP);
  end

  // PC, held instruction and retired count; only touched on their handshakes
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pc    <= bus.StartPC;
      r_imm32 <= 32'd0;
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_load_instr) begin
        r_imm32 <= bus.IMemData;
      end
      if (w_retire) begin
        r_pc    <= w_pc_nxt;
        r_count <= r_count + c_CNT_ONE;
      end
    end
  end

  assign bus.IMemReq    = w_req;
  assign bus.IMemAddr   = r_pc;
  assign bus.Imm32      = r_imm32;
  assign bus.InstrValid = w_valid;
  assign bus.InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_pc_fetch
// Brief    : Self-checking bench for next_pc_fetch: directed branch, wrap and
//            reset cases followed by randomized handshake delays and branches,
//            compared against a transaction-level PC/count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_next_pc_fetch;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  next_pc_fetch_if #(.CNT_W(CW)) bus ();

  next_pc_fetch #(.CNT_W(CW)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] pc_m;
  logic [CW-1:0] cnt_m;
  logic [31:0] imm_m;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle and land just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Randomize the resolve-side inputs; ResolveValid optionally forced low
  task automatic noise(input bit rv_ok);
    bus.ResolveValid = rv_ok ? 1'($urandom) : 1'b0;
    bus.Branch       = 1'($urandom);
    bus.Uncondbranch = 1'($urandom);
    bus.ALUZero      = 1'($urandom);
    bus.BusImm       = {$urandom, $urandom};
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_req"},   64'(bus.IMemReq),    64'd1);
    check({tag, "_addr"},  bus.IMemAddr,        pc_m);
    check({tag, "_valid"}, 64'(bus.InstrValid), 64'd0);
    check({tag, "_cnt"},   64'(bus.InstrCount), 64'(cnt_m));
    check({tag, "_imm"},   64'(bus.Imm32),      64'(imm_m));
  endtask

  task automatic check_issue(input string tag);
    check({tag, "_req"},   64'(bus.IMemReq),    64'd0);
    check({tag, "_addr"},  bus.IMemAddr,        pc_m);
    check({tag, "_valid"}, 64'(bus.InstrValid), 64'd1);
    check({tag, "_imm"},   64'(bus.Imm32),      64'(imm_m));
    check({tag, "_cnt"},   64'(bus.InstrCount), 64'(cnt_m));
  endtask

  task automatic check_resolve(input string tag);
    check({tag, "_req"},   64'(bus.IMemReq),    64'd0);
    check({tag, "_addr"},  bus.IMemAddr,        pc_m);
    check({tag, "_valid"}, 64'(bus.InstrValid), 64'd0);
    check({tag, "_cnt"},   64'(bus.InstrCount), 64'(cnt_m));
  endtask

  // Reset for two cycles with a stray ack present, then release
  task automatic reset_seq(input logic [63:0] start);
    bus.StartPC  = start;
    rst          = 1'b1;
    bus.IMemAck  = 1'b1;
    bus.IMemData = $urandom;
    noise(1'b1);
    step();
    check("rst1_req",   64'(bus.IMemReq),    64'd0);
    check("rst1_valid", 64'(bus.InstrValid), 64'd0);
    step();
    check("rst2_cnt",   64'(bus.InstrCount), 64'd0);
    check("rst2_imm",   64'(bus.Imm32),      64'd0);
    check("rst2_addr",  bus.IMemAddr,        start);
    rst = 1'b0;
    // First cycle out of reset: request still low
    check("idle_req",   64'(bus.IMemReq),    64'd0);
    step();
    bus.IMemAck = 1'b0;
    pc_m  = start;
    cnt_m = '0;
    imm_m = 32'd0;
    check_fetch("post_rst");
  endtask

  // One instruction through the loop with the given handshake delays
  task automatic do_instr(input logic [31:0] data, input int a_dly, input int r_dly,
                          input int s_dly, input bit br, input bit ub, input bit z,
                          input logic [63:0] imm);
    for (int i = 0; i < a_dly; i++) begin
      check_fetch("fwait");
      bus.IMemAck    = 1'b0;
      bus.IMemData   = $urandom;
      bus.InstrReady = 1'($urandom);
      noise(1'b1);
      step();
    end
    check_fetch("fack");
    bus.IMemAck    = 1'b1;
    bus.IMemData   = data;
    bus.InstrReady = 1'($urandom);
    noise(1'b1);
    step();
    imm_m = data;
    for (int i = 0; i < r_dly; i++) begin
      check_issue("iwait");
      bus.InstrReady = 1'b0;
      bus.IMemAck    = 1'($urandom);
      bus.IMemData   = $urandom;
      noise(1'b1);
      step();
    end
    check_issue("irdy");
    bus.InstrReady = 1'b1;
    bus.IMemAck    = 1'($urandom);
    bus.IMemData   = $urandom;
    noise(1'b1);
    step();
    for (int i = 0; i < s_dly; i++) begin
      check_resolve("rwait");
      check("rwait_imm", 64'(bus.Imm32), 64'(imm_m));
      bus.InstrReady = 1'($urandom);
      bus.IMemAck    = 1'($urandom);
      bus.IMemData   = $urandom;
      noise(1'b0);
      step();
    end
    check_resolve("rvalid");
    bus.ResolveValid = 1'b1;
    bus.Branch       = br;
    bus.Uncondbranch = ub;
    bus.ALUZero      = z;
    bus.BusImm       = imm;
    bus.IMemAck      = 1'($urandom);
    step();
    bus.IMemAck = 1'b0;
    noise(1'b1);
    pc_m  = (ub || (br && z)) ? pc_m + (imm << 2) : pc_m + 64'd4;
    cnt_m = cnt_m + 1'b1;
  endtask

  initial begin
    logic [63:0] rimm;
    bus.StartPC      = 64'd0;
    bus.BusImm       = 64'd0;
    bus.Branch       = 1'b0;
    bus.Uncondbranch = 1'b0;
    bus.ALUZero      = 1'b0;
    bus.ResolveValid = 1'b0;
    bus.IMemAck      = 1'b0;
    bus.IMemData     = 32'd0;
    bus.InstrReady   = 1'b0;
    pc_m  = 64'd0;
    cnt_m = '0;
    imm_m = 32'd0;

    // Reset and a sequential instruction
    reset_seq(64'h100);
    check("start_addr", bus.IMemAddr, 64'h100);
    do_instr(32'h8B020020, 0, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    check("seq_imm",  64'(bus.Imm32), 64'h8B020020);
    check("seq_addr", bus.IMemAddr,   64'h104);
    check("seq_cnt",  64'(bus.InstrCount), 64'd1);

    // Unconditional backward branch, then again with Branch also set
    do_instr($urandom, 0, 0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    check("ub_addr", bus.IMemAddr, 64'hFC);
    do_instr($urandom, 0, 0, 0, 1'b0, 1'b0, 1'b1, 64'd7);
    do_instr($urandom, 0, 0, 0, 1'b1, 1'b0, 1'b0, 64'd7);
    check("back_addr", bus.IMemAddr, 64'h104);
    do_instr($urandom, 0, 0, 0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    check("ubbr_addr", bus.IMemAddr, 64'hFC);

    // Conditional branch not taken / taken
    reset_seq(64'h200);
    do_instr($urandom, 0, 0, 0, 1'b1, 1'b0, 1'b0, 64'd3);
    check("cb_nt_addr", bus.IMemAddr, 64'h204);
    reset_seq(64'h200);
    do_instr($urandom, 0, 0, 0, 1'b1, 1'b0, 1'b1, 64'd3);
    check("cb_t_addr", bus.IMemAddr, 64'h20C);

    // Backpressure on every handshake
    do_instr(32'hDEADBEEF, 3, 2, 2, 1'b0, 1'b0, 1'b0, 64'd0);
    check_fetch("bp_done");

    // PC wrap
    reset_seq(64'hFFFF_FFFF_FFFF_FFFC);
    do_instr($urandom, 1, 0, 1, 1'b0, 1'b0, 1'b0, 64'd0);
    check("wrap_addr", bus.IMemAddr, 64'h0);

    // Reset while a fetch is outstanding
    do_instr($urandom, 0, 1, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 2; i++) begin
      check_fetch("pre_rst");
      bus.IMemAck = 1'b0;
      step();
    end
    reset_seq(64'h100);

    // Randomized traffic, long enough to wrap the retired counter
    for (int n = 0; n < 300; n++) begin
      rimm = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rimm = {{52{rimm[11]}}, rimm[11:0]};
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom), rimm);
    end
    check_fetch("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
